// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one fadd_s adder among NREQ requesters with in-order tag FIFO.
// Optional FADD_ARB_STICKY_OVF_EN adds per-requester sticky overflow flags (ovf_sticky, cleared by ovf_clr).
module fadd_arbiter #(
  parameter int NREQ = 2,
  parameter int MAX_INFL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      sub,
  input  logic [32*NREQ-1:0]   op_a,
  input  logic [32*NREQ-1:0]   op_b,
`ifdef FADD_ARB_STICKY_OVF_EN
  input  logic [NREQ-1:0]      ovf_clr,
  output logic [NREQ-1:0]      ovf_sticky,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_ovf,
  output logic                 err,
  output logic [31:0]          fa_x1,
  output logic [31:0]          fa_x2,
  output logic                 fa_enable_in,
  input  logic                 fa_enable_out,
  input  logic [31:0]          fa_y,
  input  logic                 fa_ovf
);
  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(MAX_INFL);
  localparam int CW = $clog2(MAX_INFL + 1);
  logic [PW-1:0] ptr, gidx;
  logic [PW-1:0] tags [MAX_INFL];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic credit, xfer, pop;
  // Scan downward so the candidate closest to ptr is the last one written.
  always_comb begin
    gidx = '0;
    credit = cnt != CW'(MAX_INFL);
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[PW'((int'(ptr) + k) % NREQ)]) gidx = PW'((int'(ptr) + k) % NREQ);
    gnt = (credit && |req) ? NREQ'(1) << gidx : '0;
    xfer = |(req & gnt);
    pop = fa_enable_out && cnt != '0;
  end
  always_ff @(posedge clk)
    if (xfer) tags[wp] <= gidx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      fa_enable_in <= 1'b0;
      fa_x1 <= '0;
      fa_x2 <= '0;
      resp_valid <= '0;
      resp_data <= '0;
      resp_ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      fa_enable_in <= xfer;
      if (xfer) begin
        ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        fa_x1 <= op_a[32*gidx +: 32];
        fa_x2 <= {op_b[32*gidx+31] ^ sub[gidx], op_b[32*gidx +: 31]};
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
        resp_data <= fa_y;
        resp_ovf <= fa_ovf;
      end
      cnt <= cnt + CW'(xfer) - CW'(pop);
      resp_valid <= pop ? NREQ'(1) << tags[rp] : '0;
      if (fa_enable_out && cnt == '0) err <= 1'b1;
    end
  end
`ifdef FADD_ARB_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_sticky <= '0;
    else ovf_sticky <= (ovf_sticky | (resp_valid & {NREQ{resp_ovf}})) & ~ovf_clr;
`endif
endmodule

// File: tb/tb_fadd_arbiter.sv
// tb_fadd_arbiter: scoreboard bench for fadd_arbiter with an 8-cycle table-driven fadd_s stub.
module tb_fadd_arbiter;
  localparam int NREQ = 2, MAX_INFL = 4, LAT = 8;
  logic clk = 0, rst_n = 0, force_eo = 0;
  always #5 clk = ~clk;
  logic [NREQ-1:0] req, sub, gnt, resp_valid;
  logic [32*NREQ-1:0] op_a, op_b;
  logic [31:0] resp_data, fa_x1, fa_x2, fa_y;
  logic resp_ovf, err, fa_enable_in, fa_enable_out, fa_ovf;
`ifdef FADD_ARB_STICKY_OVF_EN
  logic [NREQ-1:0] ovf_clr = '0, ovf_sticky;
`endif
  fadd_arbiter #(.NREQ(NREQ), .MAX_INFL(MAX_INFL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sub(sub), .op_a(op_a), .op_b(op_b),
`ifdef FADD_ARB_STICKY_OVF_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
`endif
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data), .resp_ovf(resp_ovf),
    .err(err), .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_enable_in(fa_enable_in),
    .fa_enable_out(fa_enable_out), .fa_y(fa_y), .fa_ovf(fa_ovf));

  typedef struct {logic [31:0] a, b; logic s; logic [31:0] y; logic o;} op_t;
  typedef struct {int id; logic [31:0] y; logic o;} exp_t;
  op_t ops0[$], ops1[$];
  exp_t sb[$];
  int gnt_log[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stub adder: only the hand-computed operand pairs yield a real sum.
  function automatic logic [32:0] stub_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40200000_3fc00000: return {1'b0, 32'h40800000};
      64'h41200000_c0a00000: return {1'b0, 32'h40a00000};
      64'h40000000_40000000: return {1'b0, 32'h40800000};
      64'h41200000_3e000000: return {1'b0, 32'h41220000};
      64'h3f800000_3f800000: return {1'b0, 32'h40000000};
      64'h40400000_bf800000: return {1'b0, 32'h40000000};
      64'h7f7fffff_7f7fffff: return {1'b1, 32'h7f800000};
      default:               return {1'b0, a ^ b};
    endcase
  endfunction

  logic [33:0] pipe [LAT];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    else begin
      pipe[0] <= {fa_enable_in, stub_add(fa_x1, fa_x2)};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  assign fa_enable_out = pipe[LAT-1][33] | force_eo;
  assign fa_ovf = pipe[LAT-1][32];
  assign fa_y = pipe[LAT-1][31:0];

  // Driver: present queue heads, retire them on transfer and queue expected responses.
  initial begin
    req = '0; sub = '0; op_a = '0; op_b = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req[0] && gnt[0]) begin
          sb.push_back(exp_t'{0, ops0[0].y, ops0[0].o}); gnt_log.push_back(0); void'(ops0.pop_front());
        end
        if (req[1] && gnt[1]) begin
          sb.push_back(exp_t'{1, ops1[0].y, ops1[0].o}); gnt_log.push_back(1); void'(ops1.pop_front());
        end
      end
      @(posedge clk); #1;
      req[0] = ops0.size() > 0;
      if (req[0]) begin op_a[31:0] = ops0[0].a; op_b[31:0] = ops0[0].b; sub[0] = ops0[0].s; end
      req[1] = ops1.size() > 0;
      if (req[1]) begin op_a[63:32] = ops1[0].a; op_b[63:32] = ops1[0].b; sub[1] = ops1[0].s; end
    end
  end

  always @(negedge clk)
    if (rst_n && resp_valid != '0) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp actual=%b required=none", resp_valid);
      end else begin
        e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(1 << e.id));
        chk("resp_data", resp_data, e.y);
        chk("resp_ovf", 32'(resp_ovf), 32'(e.o));
      end
    end

  task automatic do_reset();
    @(negedge clk); #2;
    ops0.delete(); ops1.delete(); sb.delete(); gnt_log.delete();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_ovf", 32'(resp_ovf), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fa_x1", fa_x1, 0);
    chk("rst_fa_x2", fa_x2, 0);
    chk("rst_fa_enable_in", 32'(fa_enable_in), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain();
    int n = 0;
    while ((ops0.size() + ops1.size() + sb.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int xf, rs, first_rv, resume, xf_before, max_infl, stall;
    do_reset();
    // Single add on requester 0
    ops0.push_back(op_t'{32'h40200000, 32'h3fc00000, 1'b0, 32'h40800000, 1'b0});
    @(posedge clk); #2;
    chk("t1_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #2;
    chk("t1_enable_in", 32'(fa_enable_in), 1);
    chk("t1_fa_x1", fa_x1, 32'h40200000);
    chk("t1_fa_x2", fa_x2, 32'h3fc00000);
    @(posedge clk); #2;
    chk("t1_enable_in_pulse", 32'(fa_enable_in), 0);
    drain();
    // Subtraction on requester 1
    ops1.push_back(op_t'{32'h41200000, 32'h40a00000, 1'b1, 32'h40a00000, 1'b0});
    @(posedge clk); #2;
    chk("t2_gnt", 32'(gnt), 32'h2);
    @(posedge clk); #2;
    chk("t2_fa_x2", fa_x2, 32'hc0a00000);
    drain();
    // Round-robin alternation from reset
    do_reset();
    ops0.push_back(op_t'{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0});
    ops0.push_back(op_t'{32'h41200000, 32'h3e000000, 1'b0, 32'h41220000, 1'b0});
    ops1.push_back(op_t'{32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000, 1'b0});
    ops1.push_back(op_t'{32'h40400000, 32'h3f800000, 1'b1, 32'h40000000, 1'b0});
    drain();
    chk("t3_xfers", 32'(gnt_log.size()), 4);
    if (gnt_log.size() == 4) begin
      chk("t3_order0", 32'(gnt_log[0]), 0);
      chk("t3_order1", 32'(gnt_log[1]), 1);
      chk("t3_order2", 32'(gnt_log[2]), 0);
      chk("t3_order3", 32'(gnt_log[3]), 1);
    end
    // Credit limit with 8-cycle adder
    do_reset();
    for (int i = 0; i < 8; i++) ops0.push_back(op_t'{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0});
    xf = 0; rs = 0; first_rv = -1; resume = -1; xf_before = -1; max_infl = 0; stall = 0;
    for (int cyc = 0; cyc < 200 && !(xf == 8 && rs == 8); cyc++) begin
      @(negedge clk); #1;
      if (resp_valid != '0 && first_rv < 0) begin first_rv = cyc; xf_before = xf; end
      if (first_rv < 0 && xf > 0 && req[0] && gnt == '0) stall = 1;
      if (req[0] && gnt[0]) begin
        xf++;
        if (first_rv >= 0 && resume < 0) resume = cyc;
      end
      if (resp_valid != '0) rs++;
      if (xf - rs > max_infl) max_infl = xf - rs;
    end
    chk("t4_done", 32'(xf == 8 && rs == 8), 1);
    chk("t4_xfers_before_resp", 32'(xf_before), 4);
    chk("t4_stall_seen", 32'(stall), 1);
    chk("t4_max_inflight_le4", 32'(max_infl <= 4), 1);
    chk("t4_resume_prompt", 32'(resume >= first_rv && resume - first_rv <= 1), 1);
    drain();
    // Spurious adder result with empty FIFO
    @(posedge clk); #1 force_eo = 1;
    @(posedge clk); #1 force_eo = 0;
    @(negedge clk);
    chk("t5_err_set", 32'(err), 1);
    chk("t5_no_resp", 32'(resp_valid), 0);
    ops1.push_back(op_t'{32'h41200000, 32'h40a00000, 1'b1, 32'h40a00000, 1'b0});
    drain();
    chk("t5_err_sticky", 32'(err), 1);
    do_reset();
`ifdef FADD_ARB_STICKY_OVF_EN
    ops1.push_back(op_t'{32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000, 1'b1});
    drain();
    chk("t6_sticky_set", 32'(ovf_sticky), 32'h2);
    ops1.push_back(op_t'{32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000, 1'b0});
    drain();
    chk("t6_sticky_hold", 32'(ovf_sticky), 32'h2);
    @(posedge clk); #1 ovf_clr = 2'b10;
    @(posedge clk); #1 ovf_clr = 2'b00;
    @(negedge clk);
    chk("t6_sticky_clr", 32'(ovf_sticky), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
